// File: rtl/simon_ctr_stream_if.sv
// Output stream carrying the buffered ciphertext words to the consumer.
// The master drives rnd_valid/rnd_data; the slave answers with rnd_ready.
interface simon_ctr_stream_if;
  logic        rnd_valid;
  logic [31:0] rnd_data;
  logic        rnd_ready;

  modport master (
    output rnd_valid,
    output rnd_data,
    input  rnd_ready
  );

  modport slave (
    input  rnd_valid,
    input  rnd_data,
    output rnd_ready
  );
endinterface

// File: rtl/simon_ctr_stream.sv
// Counter-mode request driver and output FIFO for the SIMON RNG top.
// Issues one cipher request at a time with an incrementing plaintext counter,
// rotates the key slot every REKEY_BLOCKS blocks, and buffers each ciphertext
// in a small FIFO with a registered head word for the consumer stream.
module simon_ctr_stream #(
  parameter int          DEPTH         = 4,
  parameter logic [31:0] CTR_INIT      = 32'h0000_0000,
  parameter logic [8:0]  KEY_ADDR_INIT = 9'd0,
  parameter logic [8:0]  KEY_STRIDE    = 9'd8,
  parameter int          REKEY_BLOCKS  = 16,
  parameter int          TIMEOUT       = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear_err,
  output logic                   cipher_en,
  output logic [31:0]            plaintext,
  output logic [8:0]             key_addr,
  input  logic [31:0]            cipher_out,
  input  logic                   done,
  simon_ctr_stream_if.master     rnd,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(REKEY_BLOCKS) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [BW-1:0] BLK_LAST   = BW'(REKEY_BLOCKS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [TW-1:0] tmo_reg;
  logic [BW-1:0] blk_reg;
  logic [31:0]   ctr_reg;
  logic [8:0]    key_reg;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] count_reg;
  logic [31:0]   head_reg;

  logic push, pop, tmo_expired, rekey;

  // Event decode: a push only happens on a completion while waiting, so done
  // arriving in any other state is dropped here.
  always_comb begin
    push        = (state_reg == ST_WAIT) && done;
    pop         = (count_reg != '0) && rnd.rnd_ready;
    tmo_expired = (tmo_reg == TMO_LAST);
    rekey       = push && (blk_reg == BLK_LAST);
    rd_ptr_next = rd_ptr_reg + AW'(1);
  end

  // Next-state logic; in WAIT, done is tested before expiry so a completion
  // on the last allowed cycle still counts as a good block.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (enable && (count_reg < FULL_LEVEL)) state_next = ST_REQ;
      ST_REQ:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (done)             state_next = ST_IDLE;
        else if (tmo_expired) state_next = ST_ERR;
      end
      ST_ERR:  if (clear_err) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Controller state, wait timer, plaintext counter and key slot rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      tmo_reg   <= '0;
      blk_reg   <= '0;
      ctr_reg   <= CTR_INIT;
      key_reg   <= KEY_ADDR_INIT;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_REQ)
        tmo_reg <= '0;
      else if ((state_reg == ST_WAIT) && !done)
        tmo_reg <= tmo_reg + TW'(1);
      if (push) begin
        ctr_reg <= ctr_reg + 32'd1;
        blk_reg <= rekey ? '0 : blk_reg + BW'(1);
        if (rekey)
          key_reg <= key_reg + KEY_STRIDE;
      end
    end
  end

  // FIFO storage; no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= cipher_out;
  end

  // FIFO pointers, occupancy and registered head word. The head is loaded
  // straight from cipher_out when the pushed word becomes the new head,
  // otherwise from the RAM slot behind the word being popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_next;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
      if (push && ((count_reg == '0) || ((count_reg == LW'(1)) && pop)))
        head_reg <= cipher_out;
      else if (pop && (count_reg > LW'(1)))
        head_reg <= mem[rd_ptr_next];
    end
  end

  // Output mapping; all outputs are decoded from registered state.
  always_comb begin
    cipher_en     = (state_reg == ST_REQ);
    busy          = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
    err           = (state_reg == ST_ERR);
    plaintext     = ctr_reg;
    key_addr      = key_reg;
    fifo_level    = count_reg;
    rnd.rnd_valid = (count_reg != '0);
    rnd.rnd_data  = head_reg;
  end

endmodule

// File: tb/tb_simon_ctr_stream.sv
// Self-checking bench for simon_ctr_stream: a cycle-level cipher model,
// a queue-based scoreboard of expected words and counter/key arithmetic.
module tb_simon_ctr_stream;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] CTR_INIT = 32'hFFFF_FFFE;
  localparam logic [8:0]  KEY_INIT = 9'd496;
  localparam logic [8:0]  STRIDE   = 9'd8;
  localparam int          REKEY    = 2;
  localparam int          TIMEOUT  = 64;

  logic        clk = 1'b0;
  logic        rst, enable, clear_err, done;
  logic        cipher_en, busy, err;
  logic [31:0] plaintext, cipher_out;
  logic [8:0]  key_addr;
  logic [2:0]  fifo_level;

  simon_ctr_stream_if rnd_if ();

  simon_ctr_stream #(
    .DEPTH(DEPTH), .CTR_INIT(CTR_INIT), .KEY_ADDR_INIT(KEY_INIT),
    .KEY_STRIDE(STRIDE), .REKEY_BLOCKS(REKEY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
    .cipher_en(cipher_en), .plaintext(plaintext), .key_addr(key_addr),
    .cipher_out(cipher_out), .done(done), .rnd(rnd_if),
    .fifo_level(fifo_level), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  logic [31:0] m_ctr;
  logic [8:0]  m_key;
  int          m_blk;
  bit          m_err;
  // Cipher model state
  bit          c_pend, hung, stray_done, clear_pulse, prev_ok;
  int          c_cnt, since, lat_min, lat_max;
  logic [31:0] c_pt, last_pt, hung_pt;
  bit          lat_never;
  int          en_pct, ready_pct, n_en, n_push;
  logic [31:0] pt_log [8];
  logic [8:0]  key_log [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ctr = CTR_INIT; m_key = KEY_INIT; m_blk = 0; m_err = 1'b0;
    c_pend = 1'b0; hung = 1'b0; stray_done = 1'b0; clear_pulse = 1'b0;
    prev_ok = 1'b0; since = 0; c_cnt = 0;
  endtask

  // One clock cycle: observe at the falling edge, then drive the next inputs
  // and advance the model by what the coming rising edge will do.
  task automatic step();
    bit pushing, popping, pend_obs;
    @(negedge clk);
    if (hung) begin
      since++;
      if (since == TIMEOUT + 1) begin m_err = 1'b1; hung = 1'b0; end
    end
    chk("level", 32'(fifo_level), 32'(exp_q.size()));
    chk("valid", 32'(rnd_if.rnd_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("data", rnd_if.rnd_data, exp_q[0]);
    chk("plaintext", plaintext, m_ctr);
    chk("key_addr", 32'(key_addr), 32'(m_key));
    chk("err", 32'(err), 32'(m_err));
    if (m_err) chk("busy_err", 32'(busy), 32'd0);
    if (cipher_en) begin
      chk("en_legal", 32'(prev_ok), 32'd1);
      if (n_en < 8) begin pt_log[n_en] = plaintext; key_log[n_en] = key_addr; end
      n_en++;
      last_pt = plaintext;
      if (lat_never) begin hung = 1'b1; since = 0; end
      else begin c_pend = 1'b1; c_cnt = int'($urandom_range(lat_max, lat_min)); c_pt = plaintext; end
    end
    if (c_pend || hung) chk("busy", 32'(busy), 32'd1);
    pend_obs = c_pend || hung;
    // drive phase
    pushing = 1'b0;
    if (c_pend && c_cnt == 0) begin
      done = 1'b1; cipher_out = c_pt ^ 32'hA5A5_A5A5; pushing = 1'b1; c_pend = 1'b0;
    end else begin
      if (c_pend) c_cnt--;
      done = stray_done; cipher_out = $urandom; stray_done = 1'b0;
    end
    rnd_if.rnd_ready = ($urandom_range(99) < ready_pct);
    enable    = ($urandom_range(99) < en_pct);
    clear_err = clear_pulse; clear_pulse = 1'b0;
    prev_ok = enable && (exp_q.size() < DEPTH) && !m_err && !pend_obs;
    popping = (exp_q.size() > 0) && rnd_if.rnd_ready;
    if (popping) begin
      $display("pop  %08h level %0d", exp_q[0], exp_q.size());
      void'(exp_q.pop_front());
    end
    if (pushing) begin
      exp_q.push_back(cipher_out);
      m_ctr = m_ctr + 32'd1;
      n_push++;
      m_blk++;
      if (m_blk == REKEY) begin m_blk = 0; m_key = m_key + STRIDE; end
    end
    if (clear_err) m_err = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    en_pct = 0; ready_pct = 100;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i >= 2 && exp_q.size() == 0 && !c_pend && !hung) begin ok = 1'b1; break; end
    end
    chk("drain_bound", 32'(ok), 32'd1);
  endtask

  logic [31:0] pt_tab [4];
  logic [8:0]  key_tab [6];

  initial begin
    int e0, p0;
    bit ok;
    pt_tab  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    key_tab = '{9'd496, 9'd496, 9'd504, 9'd504, 9'd0, 9'd0};
    rst = 1'b1; enable = 1'b0; clear_err = 1'b0; done = 1'b0;
    cipher_out = '0; rnd_if.rnd_ready = 1'b0;
    model_reset();
    lat_never = 1'b0; lat_min = 1; lat_max = 40; en_pct = 0; ready_pct = 0;
    n_en = 0; n_push = 0;
    repeat (3) @(negedge clk);
    chk("rst_cipher_en", 32'(cipher_en), 32'd0);
    chk("rst_plaintext", plaintext, CTR_INIT);
    chk("rst_key", 32'(key_addr), 32'(KEY_INIT));
    chk("rst_valid", 32'(rnd_if.rnd_valid), 32'd0);
    chk("rst_data", rnd_if.rnd_data, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Random traffic; the first six blocks exercise counter and key wrap
    en_pct = 100; ready_pct = 60;
    for (int i = 0; i < 1000 && n_en < 7; i++) step();
    chk("first_blocks_bound", 32'(n_en >= 7), 32'd1);
    for (int i = 0; i < 4; i++) chk("pt_wrap", pt_log[i], pt_tab[i]);
    for (int i = 0; i < 6; i++) chk("key_wrap", 32'(key_log[i]), 32'(key_tab[i]));
    en_pct = 80; ready_pct = 50; lat_max = 20;
    run(400);

    // Backpressure: a stalled consumer allows exactly DEPTH requests
    drain();
    en_pct = 100; ready_pct = 0; lat_min = 3; lat_max = 8;
    e0 = n_en;
    run(150);
    chk("bp_pulses", 32'(n_en - e0), 32'd4);
    chk("bp_level", 32'(fifo_level), 32'd4);
    chk("bp_busy", 32'(busy), 32'd0);
    ready_pct = 100; step(); ready_pct = 0;
    e0 = n_en;
    run(100);
    chk("bp_refill_pulses", 32'(n_en - e0), 32'd1);
    chk("bp_refill_level", 32'(fifo_level), 32'd4);

    // Timeout: cipher never answers
    drain();
    lat_never = 1'b1; en_pct = 100; ready_pct = 100;
    for (int i = 0; i < 50 && !hung; i++) step();
    chk("hang_bound", 32'(hung), 32'd1);
    hung_pt = m_ctr;
    for (int i = 0; i < TIMEOUT + 20 && !m_err; i++) step();
    chk("err_set", 32'(err), 32'd1);
    e0 = n_en;
    run(10);
    stray_done = 1'b1;
    run(10);
    chk("err_no_req", 32'(n_en - e0), 32'd0);
    chk("err_pt_held", plaintext, hung_pt);
    lat_never = 1'b0; lat_min = 5; lat_max = 10;
    clear_pulse = 1'b1;
    e0 = n_en;
    for (int i = 0; i < 20 && n_en == e0; i++) step();
    chk("retry_bound", 32'(n_en - e0), 32'd1);
    chk("retry_pt", last_pt, hung_pt);

    // Done on the very cycle the wait timer expires
    drain();
    lat_min = TIMEOUT; lat_max = TIMEOUT; en_pct = 100; ready_pct = 100;
    p0 = n_push;
    for (int i = 0; i < 400 && (n_push - p0) < 2; i++) step();
    chk("edge_pushes", 32'(n_push - p0), 32'd2);
    chk("edge_err", 32'(err), 32'd0);

    // Asynchronous reset mid-wait with two words buffered
    drain();
    lat_min = 10; lat_max = 10; en_pct = 100; ready_pct = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (exp_q.size() == 2 && c_pend && c_cnt < 7) begin ok = 1'b1; break; end
    end
    chk("rst_setup_bound", 32'(ok), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cipher_en", 32'(cipher_en), 32'd0);
    chk("arst_plaintext", plaintext, CTR_INIT);
    chk("arst_key", 32'(key_addr), 32'(KEY_INIT));
    chk("arst_valid", 32'(rnd_if.rnd_valid), 32'd0);
    chk("arst_data", rnd_if.rnd_data, 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    enable = 1'b0; done = 1'b0; rnd_if.rnd_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat_min = 1; lat_max = 10; en_pct = 100; ready_pct = 100;
    e0 = n_en;
    for (int i = 0; i < 20 && n_en == e0; i++) step();
    chk("post_rst_req", 32'(n_en - e0), 32'd1);
    chk("post_rst_pt", last_pt, CTR_INIT);
    ready_pct = 40;
    run(100);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/simon_ctr_stream.md
Name: simon_ctr_stream

Overview:
- Counter-mode driver and output buffer that sits directly in front of, and behind, the SIMON RNG top.
- Issues cipher requests with an incrementing 32-bit plaintext counter and selects which RNG-RAM key slot is used.
- Captures each 32-bit ciphertext on done and buffers it in a small FIFO.
- Presents the buffered words to the consumer on a valid/ready stream. Rotates the key slot every REKEY_BLOCKS blocks.

Parameters:
- DEPTH, 4, FIFO depth in 32-bit words; power of two, 2..16.
- CTR_INIT, 32'h0000_0000, counter/plaintext value after reset.
- KEY_ADDR_INIT, 9'd0, key slot address after reset.
- KEY_STRIDE, 9'd8, key_addr increment per rekey; the key occupies addr and addr+4.
- REKEY_BLOCKS, 16, blocks encrypted per key slot; at least 1.
- TIMEOUT, 1024, maximum cycles spent in WAIT before declaring an error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; permits new cipher requests
- clear_err  in  1  pulse; leaves ERR state
- cipher_en  out  1  one-cycle request pulse to the cipher top
- plaintext  out  32  current counter value; stable from the REQ cycle through done
- key_addr  out  9  key slot base address; stable from the REQ cycle through done
- cipher_out  in  32  ciphertext from the cipher top; valid in the cycle done=1
- done  in  1  one-cycle completion pulse from the cipher top
- rnd_valid  out  1  FIFO non-empty
- rnd_data  out  32  FIFO head word
- rnd_ready  in  1  consumer accepts the head word when rnd_valid=1
- fifo_level  out  $clog2(DEPTH)+1  words currently held
- busy  out  1  high in REQ or WAIT
- err  out  1  high in ERR

Behaviour:
- Reset values:
  - Outputs: cipher_en=0, plaintext=CTR_INIT, key_addr=KEY_ADDR_INIT, rnd_valid=0, rnd_data=0, fifo_level=0, busy=0, err=0.
  - Internal: FIFO emptied, block count=0, timeout count=0, state=IDLE.
- State machine, states IDLE, REQ, WAIT, ERR:
  - IDLE: go to REQ when enable=1 and fifo_level<DEPTH, evaluated with the current-cycle level.
  - REQ: cipher_en=1 for exactly this one cycle; clear the timeout counter; next state WAIT.
  - WAIT, done=1:
    - Push cipher_out into the FIFO and increment plaintext by 1 (mod 2^32; FFFF_FFFF wraps to 0000_0000).
    - Increment the block count. If it reaches REKEY_BLOCKS, set key_addr=key_addr+KEY_STRIDE (mod 512) and clear the block count.
    - Next state IDLE.
  - WAIT, done=0: increment the timeout counter. When TIMEOUT cycles have elapsed in WAIT without done, go to ERR.
  - ERR: err=1 and no requests. done is ignored. On clear_err=1 go to IDLE with err=0. plaintext is not advanced, so the same counter value is retried.
- Single outstanding request only. Entry to REQ requires a free slot, and pops only free slots, so the push on done never overflows.
- done outside WAIT is ignored: no push and no counter change.
- If done and timeout expiry occur in the same cycle, done wins and the block completes normally.
- enable deasserted during REQ/WAIT: the in-flight block completes and is pushed; no new request is issued.
- Back-to-back blocks need a minimum of 3 cycles each (IDLE→REQ→WAIT) plus the cipher latency.
- FIFO:
  - Synchronous, registered head. A word pushed into an empty FIFO shows rnd_valid=1 on the cycle after done.
  - A pop occurs when rnd_valid && rnd_ready. Simultaneous push and pop leaves fifo_level unchanged.
  - rnd_ready with rnd_valid=0 has no effect. Order is strictly FIFO.
- fifo_level is updated on the same clock edge as the push/pop.
- Reset mid-operation returns to reset values immediately and discards buffered words and the in-flight block. The system rst must also reset the cipher top.

Test Plan:
- Basic: defaults, enable=1, rnd_ready=1, cipher model returning done 40 cycles after cipher_en with cipher_out=plaintext^32'hA5A5_A5A5 → the first three rnd_data are A5A5A5A5, A5A5A5A4, A5A5A5A7, and cipher_en pulses exactly once per block.
- Backpressure: DEPTH=4, rnd_ready=0 → exactly 4 cipher_en pulses, then fifo_level=4, no further pulses, busy=0. Pop one word → exactly one new request.
- Rekey/wrap: REKEY_BLOCKS=2, KEY_ADDR_INIT=9'd496 → key_addr sequence 496,496,504,504,0,0, held stable between each cipher_en and its done.
- Counter wrap: CTR_INIT=32'hFFFF_FFFE → plaintexts FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Timeout: TIMEOUT=64, model never asserts done → err=1 exactly 64 cycles after entering WAIT, no further cipher_en. A stray done in ERR is ignored. clear_err → the retried request carries the same plaintext.
- Edge events: done in the same cycle as timeout expiry → word pushed and err stays 0. Async rst asserted mid-WAIT with 2 words buffered → all outputs at reset values, fifo_level=0, plaintext=CTR_INIT.
